// File: rtl/mem_port_arbiter.sv
// Arbiter that shares the block-wide memory port between icache refills and
// dcache write-backs/refills, one whole-block transaction at a time.
//
// Ports:
//   clk, rst_n            rising-edge clock, async active-low reset
//   i_req/i_addr          icache refill request (held until i_done)
//   i_rdata/i_done        icache refill block and one-cycle completion pulse
//   d_req/d_we/d_addr     dcache request (1 = write-back, 0 = refill)
//   d_wdata               dcache write-back block
//   d_rdata/d_done        dcache refill block and one-cycle completion pulse
//   mem_addr/mem_re/mem_we/mem_wdata/mem_rdata  shared memory port
//   busy                  high whenever a transaction is in progress
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants on ties;
// otherwise the dcache wins every tie.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int BLOCK_W = 1024,
    parameter int MEM_LAT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_req,
    input  logic [ADDR_W-1:0]  i_addr,
    output logic [BLOCK_W-1:0] i_rdata,
    output logic               i_done,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [ADDR_W-1:0]  d_addr,
    input  logic [BLOCK_W-1:0] d_wdata,
    output logic [BLOCK_W-1:0] d_rdata,
    output logic               d_done,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_re,
    output logic               mem_we,
    output logic [BLOCK_W-1:0] mem_wdata,
    input  logic [BLOCK_W-1:0] mem_rdata,
    output logic               busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic OWN_D = 1'b0;
    localparam logic OWN_I = 1'b1;

    localparam logic [7:0] CNT_INIT = 8'(MEM_LAT - 1);
    localparam logic [ADDR_W-1:0] ALIGN = {{(ADDR_W-7){1'b1}}, 7'b0};

    logic [1:0] state;
    logic [7:0] cnt;
    logic       owner;
    logic       last_grant;
    logic       grant_i;

    // grant_i selects the icache; otherwise the dcache is granted.
    always_comb begin
        grant_i = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        grant_i = i_req && (!d_req || (last_grant == OWN_D));
`else
        grant_i = i_req && !d_req;
`endif
    end

    assign busy   = (state != S_IDLE);
    assign i_done = (state == S_DONE) && (owner == OWN_I);
    assign d_done = (state == S_DONE) && (owner == OWN_D);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            owner      <= OWN_D;
            last_grant <= OWN_I;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (i_req || d_req) begin
                        cnt   <= CNT_INIT;
                        state <= S_ACCESS;
                        if (grant_i) begin
                            owner     <= OWN_I;
                            mem_addr  <= i_addr & ALIGN;
                            mem_wdata <= '0;
                            mem_re    <= 1'b1;
                            mem_we    <= 1'b0;
                        end else begin
                            owner     <= OWN_D;
                            mem_addr  <= d_addr & ALIGN;
                            mem_wdata <= d_wdata;
                            mem_re    <= !d_we;
                            mem_we    <= d_we;
                        end
                    end
                end
                S_ACCESS: begin
                    if (cnt == 8'd0) begin
                        mem_re <= 1'b0;
                        mem_we <= 1'b0;
                        // only reads update the requester's block register
                        if (mem_re) begin
                            if (owner == OWN_I) begin
                                i_rdata <= mem_rdata;
                            end else begin
                                d_rdata <= mem_rdata;
                            end
                        end
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_DONE: begin
                    if (last_grant != owner) begin
                        last_grant <= owner;
                    end
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
